// File: rtl/add_acc_16_pkg.sv
// Shared types and widths for the framed 16-bit add-accumulator.
package add_acc_16_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

endpackage : add_acc_16_pkg

// File: rtl/add_acc_16_rca.sv
// 16-bit ripple-carry adder; one full-adder cell per bit, carry chained LSB to MSB.
module Add_rca_16
  import add_acc_16_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] sum,
  output logic              c_out
);

  logic [DATA_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < int'(DATA_W); i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[DATA_W];
  end

endmodule : Add_rca_16

// File: rtl/add_acc_16.sv
// Accumulates FRAME_LEN unsigned operands per frame and presents the wrapped sum
// plus a sticky carry flag through a valid/ready result handshake.
module add_acc_16
  import add_acc_16_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_sum_q, out_sum_d;
  logic                out_ovf_q, out_ovf_d;

  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;
  logic                accept_c;
  logic                handshake_c;

  Add_rca_16 u_add (
    .a     (acc_q),
    .b     (in_data),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // in_ready_q stays low for the first cycle out of reset, so it gates acceptance.
  assign accept_c    = in_valid & in_ready_q;
  assign handshake_c = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept_c) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_cout;
            if (cnt_q == LAST_CNT) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (handshake_c) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end

    // Result fields read zero whenever no result is being presented.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    out_sum_d   = out_valid_d ? acc_d : '0;
    out_ovf_d   = out_valid_d ? ovf_d : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule : add_acc_16

// File: doc/add_acc_16.md
ADD_ACC_16 -- requirements
Module: add_acc_16

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, giving operands per accumulation frame (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clr, input, 1, synchronous frame abort/clear.
REQ-005 The block SHALL have port in_valid, input, 1, operand present.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts operand.
REQ-007 The block SHALL have port in_data, input, 16, unsigned operand.
REQ-008 The block SHALL have port out_valid, output, 1, frame result present.
REQ-009 The block SHALL have port out_ready, input, 1, downstream accepts result.
REQ-010 The block SHALL have port out_sum, output, 16, frame sum modulo 2^16.
REQ-011 The block SHALL have port out_ovf, output, 1, sticky unsigned carry-out seen in frame.

Function
REQ-012 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-013 An operand SHALL be accepted on a rising edge with in_valid=1 and in_ready=1, and only then.
REQ-014 On accept: acc <= acc + in_data (16-bit add, carry-in 0); ovf <= ovf OR carry-out; cnt <= cnt+1.
REQ-015 On accept with cnt = FRAME_LEN-1: the FSM SHALL go to DONE, with the final acc/ovf registered in the same edge.
REQ-016 Latency: out_valid SHALL assert in the cycle immediately after the last operand is accepted.
REQ-017 In DONE: out_sum=acc and out_ovf=ovf, held stable until handshake; in_valid is ignored.
REQ-018 A handshake SHALL occur on an edge where out_valid=1 and out_ready=1; then acc, ovf, and cnt clear to 0 and the FSM returns to ACCUM.
REQ-019 The first operand of the next frame SHALL NOT be accepted earlier than the cycle after the handshake (one-cycle bubble).
REQ-020 out_sum and out_ovf SHALL read 0 whenever out_valid=0.
REQ-021 Wrap-around: the sum SHALL wrap modulo 2^16, and ovf SHALL stay 1 once set until the frame ends.
REQ-022 clr=1 SHALL clear acc, ovf, and cnt and force ACCUM on the next edge, in any state.
REQ-023 clr SHALL have priority over simultaneous operand accept and output handshake; a result presented in that cycle is discarded.
REQ-024 cnt SHALL be 8 bits wide and never exceed FRAME_LEN-1.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force acc=0, ovf=0, cnt=0, FSM=ACCUM.
REQ-026 During reset: in_ready=0, out_valid=0, out_sum=0, out_ovf=0.
REQ-027 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-028 Reset asserted mid-frame or in DONE SHALL discard all partial or pending results.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (ACCUM, DONE), data width 16, and counter width 8.
REQ-030 The adder SHALL be one instance of the team's existing 16-bit ripple-carry adder Add_rca_16, with c_in tied to 0 and c_out feeding ovf.
REQ-031 No other sub-module SHALL be used; the FSM, counter, and registers SHALL be local to add_acc_16.

Verification (FRAME_LEN=4)
REQ-032 Reset test: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, out_sum=0x0000; first cycle after release -> in_ready=1.
REQ-033 Basic frame: operands 1,2,3,4 on back-to-back cycles with out_ready=1 -> one cycle after the 4th: out_valid=1, out_sum=0x000A, out_ovf=0; the next cycle returns to in_ready=1.
REQ-034 Wrap test: operands 0xFFFF, 0x0002, 0x0000, 0x0000 -> out_sum=0x0001, out_ovf=1; the following frame 1,1,1,1 -> out_sum=0x0004, out_ovf=0.
REQ-035 Backpressure test: after frame 5,5,5,5 hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid stays 1, out_sum=0x0014 stable, in_ready=0, no operand consumed.
REQ-036 Clear test: accept 0x0100, 0x0200, pulse clr, then accept 1,2,3,4 -> out_sum=0x000A; clr coincident with a handshake -> no result delivered and the FSM is in ACCUM.
REQ-037 Async reset test: drop rst_n between clock edges mid-frame and again while in DONE -> outputs zero immediately; the next full frame sums only post-reset operands.
